// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported Memory between fetch (F) and data (M) requesters.
// Optional trace/checker build: define MEM_ARB_TRACE_EN.
module mem_port_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_ack,
   output logic [31:0] f_rdata,
   input  logic        m_req,
   input  logic        m_we,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   output logic        m_ack,
   output logic [31:0] m_rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_value,
   output logic        mem_enable_write,
   input  logic [31:0] mem_read_value
);
   typedef enum logic [1:0] {IDLE, GNT_F, GNT_M} state_t;
   state_t      state_q, state_d;
   logic        f_ack_q, f_ack_d, m_ack_q, m_ack_d, we_q, we_d;
   logic [31:0] f_rdata_q, f_rdata_d, m_rdata_q, m_rdata_d;
   logic [31:0] addr_q, addr_d, wval_q, wval_d;
   logic        f_elig, m_elig;
   // Grant decision: a requester is not re-granted in its own ack cycle; M wins ties.
   always_comb begin
      f_elig    = f_req && state_q != GNT_F;
      m_elig    = m_req && state_q != GNT_M;
      state_d   = m_elig ? GNT_M : f_elig ? GNT_F : IDLE;
      addr_d    = m_elig ? m_addr : f_elig ? f_addr : addr_q;
      wval_d    = m_elig ? m_wdata : wval_q;
      we_d      = m_elig && m_we;
      f_ack_d   = state_q == GNT_F;
      m_ack_d   = state_q == GNT_M;
      f_rdata_d = state_q == GNT_F ? mem_read_value : f_rdata_q;
      m_rdata_d = (state_q == GNT_M && !we_q) ? mem_read_value : m_rdata_q;
   end
   // State and registered outputs; reset also suppresses the ack of an in-flight grant.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         f_ack_q   <= 1'b0;
         m_ack_q   <= 1'b0;
         we_q      <= 1'b0;
         f_rdata_q <= '0;
         m_rdata_q <= '0;
         addr_q    <= '0;
         wval_q    <= '0;
      end else begin
         state_q   <= state_d;
         f_ack_q   <= f_ack_d;
         m_ack_q   <= m_ack_d;
         we_q      <= we_d;
         f_rdata_q <= f_rdata_d;
         m_rdata_q <= m_rdata_d;
         addr_q    <= addr_d;
         wval_q    <= wval_d;
      end
   end
   assign f_ack            = f_ack_q;
   assign m_ack            = m_ack_q;
   assign f_rdata          = f_rdata_q;
   assign m_rdata          = m_rdata_q;
   assign mem_address      = addr_q;
   assign mem_write_value  = wval_q;
   assign mem_enable_write = we_q;
`ifdef MEM_ARB_TRACE_EN
   // Grant trace and protocol checker for simulation builds.
   always @(posedge clock) begin
      if (!reset) begin
         if (state_d == GNT_F)
            $display("%0t arb: grant F addr=%h R", $time, f_addr);
         if (state_d == GNT_M && m_we)
            $display("%0t arb: grant M addr=%h W data=%h", $time, m_addr, m_wdata);
         if (state_d == GNT_M && !m_we)
            $display("%0t arb: grant M addr=%h R", $time, m_addr);
         if (f_ack_q && m_ack_q) begin
            $display("%0t arb ERROR: f_ack and m_ack both high", $time);
            $stop;
         end
         if (we_q && state_q != GNT_M) begin
            $display("%0t arb ERROR: mem_enable_write outside GNT_M", $time);
            $stop;
         end
      end
   end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a negedge memory model.
module tb_mem_port_arbiter;
   logic        clock = 1'b0, reset = 1'b1;
   logic        f_req = 1'b0, m_req = 1'b0, m_we = 1'b0;
   logic [31:0] f_addr = '0, m_addr = '0, m_wdata = '0;
   logic        f_ack, m_ack, mem_enable_write;
   logic [31:0] f_rdata, m_rdata, mem_address, mem_write_value;
   logic [31:0] mem_read_value = '0;
   logic [31:0] mem [16];
   int          n_cmp = 0, n_bad = 0, n_fa = 0, n_ma = 0, n_we = 0;

   mem_port_arbiter dut (
      .clock(clock), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata),
      .mem_address(mem_address), .mem_write_value(mem_write_value),
      .mem_enable_write(mem_enable_write), .mem_read_value(mem_read_value)
   );

   always #5 clock = ~clock;

   function automatic logic [3:0] idx(input logic [31:0] a);
      return {a[22], a[4:2]};
   endfunction

   // Memory model: write then read at negedge, like the real Memory block.
   always @(negedge clock) begin
      if (mem_enable_write) mem[idx(mem_address)] = mem_write_value;
      mem_read_value = mem[idx(mem_address)];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (f_ack) n_fa++;
      if (m_ack) n_ma++;
      if (mem_enable_write) n_we++;
      if (f_ack && m_ack) check("ack_overlap", 32'd1, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      mem[idx(32'h0040_0000)] = 32'h2008_0005;
      mem[idx(32'h7FFF_FFFC)] = 32'h1234_5678;
      // reset and idle
      tick(); tick();
      check("rst_f_ack", {31'd0, f_ack}, 32'd0);
      check("rst_m_ack", {31'd0, m_ack}, 32'd0);
      check("rst_we", {31'd0, mem_enable_write}, 32'd0);
      check("rst_addr", mem_address, 32'd0);
      check("rst_wval", mem_write_value, 32'd0);
      check("rst_f_rdata", f_rdata, 32'd0);
      check("rst_m_rdata", m_rdata, 32'd0);
      reset = 1'b0;
      n_fa = 0; n_ma = 0; n_we = 0;
      for (int i = 0; i < 10; i++) tick();
      check("idle_acks", n_fa + n_ma + n_we, 32'd0);
      check("idle_addr", mem_address, 32'd0);
      // single fetch, held for a second grant
      f_req = 1'b1; f_addr = 32'h0040_0000;
      tick();
      check("f_addr_out", mem_address, 32'h0040_0000);
      check("f_ack_early", {31'd0, f_ack}, 32'd0);
      tick();
      check("f_ack", {31'd0, f_ack}, 32'd1);
      check("f_rdata", f_rdata, 32'h2008_0005);
      tick();
      check("f_ack_gap", {31'd0, f_ack}, 32'd0);
      tick();
      check("f_ack2", {31'd0, f_ack}, 32'd1);
      f_req = 1'b0;
      tick();
      check("f_ack_off", {31'd0, f_ack}, 32'd0);
      // simultaneous F and M load: M first
      f_req = 1'b1; m_req = 1'b1; m_we = 1'b0; m_addr = 32'h7FFF_FFFC;
      tick();
      check("mf_addr_m", mem_address, 32'h7FFF_FFFC);
      check("mf_no_ack", {30'd0, f_ack, m_ack}, 32'd0);
      tick();
      check("mf_m_ack", {30'd0, f_ack, m_ack}, 32'd1);
      check("mf_m_rdata", m_rdata, 32'h1234_5678);
      check("mf_addr_f", mem_address, 32'h0040_0000);
      m_req = 1'b0;
      tick();
      check("mf_f_ack", {30'd0, f_ack, m_ack}, 32'd2);
      check("mf_f_rdata", f_rdata, 32'h2008_0005);
      f_req = 1'b0;
      tick();
      check("mf_quiet", {30'd0, f_ack, m_ack}, 32'd0);
      // store then load
      n_we = 0;
      m_req = 1'b1; m_we = 1'b1; m_addr = 32'h7FFF_FFF8; m_wdata = 32'hDEAD_BEEF;
      tick();
      check("st_we", {31'd0, mem_enable_write}, 32'd1);
      check("st_wval", mem_write_value, 32'hDEAD_BEEF);
      check("st_addr", mem_address, 32'h7FFF_FFF8);
      tick();
      check("st_ack", {31'd0, m_ack}, 32'd1);
      check("st_rdata_hold", m_rdata, 32'h1234_5678);
      check("st_we_off", {31'd0, mem_enable_write}, 32'd0);
      m_we = 1'b0;
      tick();
      check("ld_we", {31'd0, mem_enable_write}, 32'd0);
      tick();
      check("ld_ack", {31'd0, m_ack}, 32'd1);
      check("ld_rdata", m_rdata, 32'hDEAD_BEEF);
      m_req = 1'b0;
      tick();
      check("st_we_count", n_we, 32'd1);
      // continuous F and M: strict alternation
      n_fa = 0; n_ma = 0;
      f_req = 1'b1; m_req = 1'b1; m_addr = 32'h7FFF_FFFC;
      for (int i = 1; i <= 21; i++) begin
         tick();
         check($sformatf("alt_%0d", i), {30'd0, f_ack, m_ack},
               i == 1 ? 32'd0 : (i % 2 == 0 ? 32'd1 : 32'd2));
      end
      check("alt_f_count", n_fa, 32'd10);
      check("alt_m_count", n_ma, 32'd10);
      f_req = 1'b0; m_req = 1'b0;
      tick();
      check("alt_tail_m", {30'd0, f_ack, m_ack}, 32'd1);
      tick();
      check("alt_tail_idle", {30'd0, f_ack, m_ack}, 32'd0);
      // reset during GNT_M of a load
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h7FFF_FFFC;
      tick();
      reset = 1'b1;
      tick();
      check("rg_m_ack", {31'd0, m_ack}, 32'd0);
      check("rg_m_rdata", m_rdata, 32'd0);
      check("rg_we", {31'd0, mem_enable_write}, 32'd0);
      reset = 1'b0;
      tick();
      check("rg_regrant", {30'd0, f_ack, m_ack}, 32'd0);
      check("rg_addr", mem_address, 32'h7FFF_FFFC);
      tick();
      check("rg_ack", {31'd0, m_ack}, 32'd1);
      check("rg_rdata", m_rdata, 32'h1234_5678);
      m_req = 1'b0;
      tick();
      check("rg_done", {30'd0, f_ack, m_ack}, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported `Memory` block between the instruction-fetch requester (F) and the MEM-stage data requester (M). Registers one access per cycle onto the memory's `address`/`write_value`/`enable_write` inputs, captures `read_value` after the memory's negedge access, and returns it with a one-cycle acknowledge pulse. Requesters stall on their own request until acknowledged.

## Interface
- No parameters.
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `f_req`  in  1  fetch request; held high with `f_addr` stable until `f_ack`.
- `f_addr`  in  32  fetch byte address.
- `f_ack`  out  1  one-cycle pulse: `f_rdata` valid this cycle.
- `f_rdata`  out  32  fetched word.
- `m_req`  in  1  data request; held with `m_we`/`m_addr`/`m_wdata` stable until `m_ack`.
- `m_we`  in  1  1 = store, 0 = load.
- `m_addr`  in  32  data byte address.
- `m_wdata`  in  32  store data.
- `m_ack`  out  1  one-cycle pulse: load data valid or store done.
- `m_rdata`  out  32  load data.
- `mem_address`  out  32  to `Memory.address`, registered.
- `mem_write_value`  out  32  to `Memory.write_value`, registered.
- `mem_enable_write`  out  1  to `Memory.enable_write`, registered.
- `mem_read_value`  in  32  from `Memory.read_value`.

## Operation
- States: `IDLE`, `GNT_F`, `GNT_M`. Each grant state lasts exactly one cycle.
- Grant decision at every posedge, from IDLE or from either grant state:
  - Eligible F: `f_req` high and the state being left is not `GNT_F`.
  - Eligible M: `m_req` high and the state being left is not `GNT_M`.
  - Both eligible: M wins. Data priority prevents a pipeline deadlock with a stalled MEM stage.
  - Neither eligible: go to `IDLE`.
- Ineligibility blocks re-granting a requester in its own ack cycle, when its request is still high for the old access.
- Consequences:
  - One requester alone gets one access every 2 cycles.
  - Alternating F/M sustains one access per cycle.
  - M cannot starve F, because F becomes eligible in every cycle after a `GNT_M`.
- On entering `GNT_F`:
  - `mem_address <= f_addr`
  - `mem_enable_write <= 0`
- On entering `GNT_M`:
  - `mem_address <= m_addr`
  - `mem_write_value <= m_wdata`
  - `mem_enable_write <= m_we`
- On entering `IDLE`:
  - `mem_enable_write <= 0`
  - `mem_address` and `mem_write_value` hold.
- On leaving `GNT_F`:
  - `f_rdata <= mem_read_value`
  - `f_ack <= 1` for one cycle.
- On leaving `GNT_M`:
  - `m_ack <= 1` for one cycle.
  - Load: `m_rdata <= mem_read_value`.
  - Store: `m_rdata` holds.
- Otherwise both acks are 0. F and M acks are never high in the same cycle.
- Address decode, out-of-range handling and the undefined-value marker belong to `Memory`. The arbiter passes data through unmodified.

## Timing
- Reset values:
  - State `IDLE`.
  - `f_ack`, `m_ack`, `mem_enable_write` = 0.
  - `f_rdata`, `m_rdata`, `mem_address`, `mem_write_value` = 0.
- Latency, for a request sampled at posedge k and granted:
  - mem_* outputs are driven during cycle k..k+1.
  - `Memory` samples them at the intervening negedge.
  - ack and data are registered at posedge k+1 and valid for cycle k+1..k+2.
- A losing requester waits; its eligibility is re-evaluated every posedge with no queueing.
- A request dropped before ack (protocol violation) is ignored if not yet granted. If already granted, the ack is still issued.
- Reset during a grant cycle:
  - No ack is issued; state goes to `IDLE`.
  - A store in that cycle may already have been committed by `Memory` at the negedge. Software-visible state after reset does not depend on it.
- `mem_enable_write` is high for at most one cycle per granted store and never during `GNT_F` or `IDLE`.

## Configuration
- `MEM_ARB_TRACE_EN` defined:
  - Every grant `$display`s time, requester (F/M), address and R/W.
  - Every store additionally shows the data.
  - Any F and M ack both high, or `mem_enable_write` high outside `GNT_M`, prints an error and calls `$stop`.
- Not defined: no display or checker logic is compiled. Functional behaviour is identical.

## Test plan
- Reset held 2 cycles, then released with no requests -> all outputs 0, state `IDLE`, no acks for 10 cycles.
- `f_req`=1, `f_addr`=0x0040_0000, memory word 0x2008_0005 -> `mem_address`=0x0040_0000 one cycle after the request, `f_ack` pulse next cycle with `f_rdata`=0x2008_0005; with `f_req` held, the next grant is 2 cycles later.
- `f_req` and `m_req` (load 0x7FFF_FFFC, stored value 0x1234_5678) raised in the same cycle -> M granted first, `m_rdata`=0x1234_5678; F granted the next cycle; acks on consecutive cycles, never overlapping.
- M store 0xDEAD_BEEF to 0x7FFF_FFF8, then load of the same address -> `mem_enable_write` high exactly one cycle; load returns 0xDEAD_BEEF; `m_rdata` unchanged at the store ack.
- F and M requests held continuously for 20 cycles -> grants strictly alternate M,F,M,F; 10 acks each; no cycle without an ack after the first.
- Reset asserted during `GNT_M` of a load -> no `m_ack`, state `IDLE`, `m_rdata`=0 next cycle; the request re-issued after reset completes normally.
